// File: rtl/jtag_tap_fsm.sv
// jtag_tap_fsm: IEEE 1149.1 TAP controller running on the system clock.
// The TCK/TMS/TDI pins are oversampled on ICLK. The 16-state TAP machine
// advances once per detected TCK rising edge. Single-cycle strobes drive the
// IR and DR cells, and TDO is launched on TCK falling edges.
module jtag_tap_fsm #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       ICLK,
  input  logic       reset,
  input  logic       tck,
  input  logic       tms,
  input  logic       tdi,
  input  logic       ir_s_out,
  input  logic       dr_s_out,
  output logic       tdo,
  output logic       tdo_oe,
  output logic       shift_ir,
  output logic       clk_ir,
  output logic       update_ir,
  output logic       shift_dr,
  output logic       clk_dr,
  output logic       update_dr,
  output logic       test_logic_reset,
  output logic [3:0] tap_state
);

  // TAP state encodings (the values visible on tap_state)
  localparam logic [3:0] ST_TLR    = 4'hF;
  localparam logic [3:0] ST_RTI    = 4'hC;
  localparam logic [3:0] ST_SELDR  = 4'h7;
  localparam logic [3:0] ST_CAPDR  = 4'h6;
  localparam logic [3:0] ST_SHDR   = 4'h2;
  localparam logic [3:0] ST_EX1DR  = 4'h1;
  localparam logic [3:0] ST_PSDR   = 4'h3;
  localparam logic [3:0] ST_EX2DR  = 4'h0;
  localparam logic [3:0] ST_UPDDR  = 4'h5;
  localparam logic [3:0] ST_SELIR  = 4'h4;
  localparam logic [3:0] ST_CAPIR  = 4'hE;
  localparam logic [3:0] ST_SHIR   = 4'hA;
  localparam logic [3:0] ST_EX1IR  = 4'h9;
  localparam logic [3:0] ST_PSIR   = 4'hB;
  localparam logic [3:0] ST_EX2IR  = 4'h8;
  localparam logic [3:0] ST_UPDIR  = 4'hD;

  logic [SYNC_STAGES-1:0] tck_sync_r;
  logic [SYNC_STAGES-1:0] tms_sync_r;
  logic [SYNC_STAGES-1:0] tdi_sync_r;
  logic                   tck_prev_r;
  logic                   tck_s;
  logic                   tms_s;
  logic                   tck_rise_s;
  logic                   tck_fall_s;
  logic [3:0]             state_r;
  logic [3:0]             next_state_s;
  logic                   tdo_r;
  logic                   tdo_oe_r;
  logic                   unused_tdi_s;

  // The synchronised tdi has no consumer inside the controller itself
  assign unused_tdi_s = ^tdi_sync_r;

  // Pin synchronisers: all three pins see the same delay so tms/tdi stay aligned with tck
  always_ff @(posedge ICLK or posedge reset) begin
    if (reset) begin
      tck_sync_r <= {SYNC_STAGES{1'b0}};
      tms_sync_r <= {SYNC_STAGES{1'b0}};
      tdi_sync_r <= {SYNC_STAGES{1'b0}};
      tck_prev_r <= 1'b0;
    end else begin
      tck_sync_r <= {tck_sync_r[SYNC_STAGES-2:0], tck};
      tms_sync_r <= {tms_sync_r[SYNC_STAGES-2:0], tms};
      tdi_sync_r <= {tdi_sync_r[SYNC_STAGES-2:0], tdi};
      tck_prev_r <= tck_sync_r[SYNC_STAGES-1];
    end
  end

  assign tck_s      = tck_sync_r[SYNC_STAGES-1];
  assign tms_s      = tms_sync_r[SYNC_STAGES-1];
  assign tck_rise_s = tck_s & ~tck_prev_r;
  assign tck_fall_s = ~tck_s & tck_prev_r;

  // TAP state register
  always_ff @(posedge ICLK or posedge reset) begin
    if (reset) begin
      state_r <= ST_TLR;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state logic: the machine only moves on a detected TCK rise
  always_comb begin
    next_state_s = state_r;
    if (tck_rise_s) begin
      case (state_r)
        ST_TLR:   next_state_s = tms_s ? ST_TLR   : ST_RTI;
        ST_RTI:   next_state_s = tms_s ? ST_SELDR : ST_RTI;
        ST_SELDR: next_state_s = tms_s ? ST_SELIR : ST_CAPDR;
        ST_CAPDR: next_state_s = tms_s ? ST_EX1DR : ST_SHDR;
        ST_SHDR:  next_state_s = tms_s ? ST_EX1DR : ST_SHDR;
        ST_EX1DR: next_state_s = tms_s ? ST_UPDDR : ST_PSDR;
        ST_PSDR:  next_state_s = tms_s ? ST_EX2DR : ST_PSDR;
        ST_EX2DR: next_state_s = tms_s ? ST_UPDDR : ST_SHDR;
        ST_UPDDR: next_state_s = tms_s ? ST_SELDR : ST_RTI;
        ST_SELIR: next_state_s = tms_s ? ST_TLR   : ST_CAPIR;
        ST_CAPIR: next_state_s = tms_s ? ST_EX1IR : ST_SHIR;
        ST_SHIR:  next_state_s = tms_s ? ST_EX1IR : ST_SHIR;
        ST_EX1IR: next_state_s = tms_s ? ST_UPDIR : ST_PSIR;
        ST_PSIR:  next_state_s = tms_s ? ST_EX2IR : ST_PSIR;
        ST_EX2IR: next_state_s = tms_s ? ST_UPDIR : ST_SHIR;
        ST_UPDIR: next_state_s = tms_s ? ST_SELDR : ST_RTI;
        default:  next_state_s = ST_TLR;
      endcase
    end else begin
      next_state_s = state_r;
    end
  end

  // Cell strobes decode the pre-transition state so cells clocked alongside see the old state
  always_comb begin
    shift_ir         = (state_r == ST_SHIR);
    shift_dr         = (state_r == ST_SHDR);
    clk_ir           = tck_rise_s & ((state_r == ST_CAPIR) | (state_r == ST_SHIR));
    clk_dr           = tck_rise_s & ((state_r == ST_CAPDR) | (state_r == ST_SHDR));
    update_ir        = tck_fall_s & (state_r == ST_UPDIR);
    update_dr        = tck_fall_s & (state_r == ST_UPDDR);
    test_logic_reset = (state_r == ST_TLR);
  end

  // TDO launch on TCK fall from whichever chain is shifting; otherwise tristate and hold
  always_ff @(posedge ICLK or posedge reset) begin
    if (reset) begin
      tdo_r    <= 1'b0;
      tdo_oe_r <= 1'b0;
    end else if (tck_fall_s) begin
      case (state_r)
        ST_SHIR: begin
          tdo_r    <= ir_s_out;
          tdo_oe_r <= 1'b1;
        end
        ST_SHDR: begin
          tdo_r    <= dr_s_out;
          tdo_oe_r <= 1'b1;
        end
        default: begin
          tdo_r    <= tdo_r;
          tdo_oe_r <= 1'b0;
        end
      endcase
    end else begin
      tdo_r    <= tdo_r;
      tdo_oe_r <= tdo_oe_r;
    end
  end

  assign tdo       = tdo_r;
  assign tdo_oe    = tdo_oe_r;
  assign tap_state = state_r;

endmodule

// File: tb/tb_jtag_tap_fsm.sv
// tb_jtag_tap_fsm: directed scenarios followed by randomized TCK/TMS traffic,
// checked against a table-driven model of the TAP state graph.
module tb_jtag_tap_fsm;

  localparam int PH = 6;  // ICLK cycles per TCK phase

  logic       ICLK = 1'b0;
  logic       reset, tck, tms, tdi, ir_s_out, dr_s_out;
  logic       tdo, tdo_oe, shift_ir, clk_ir, update_ir;
  logic       shift_dr, clk_dr, update_dr, test_logic_reset;
  logic [3:0] tap_state;

  int tests = 0;
  int errs  = 0;

  // Model: states indexed in the 1149.1 diagram order
  // 0 TLR 1 RTI 2 SelDR 3..8 DR column (Cap,Sh,Ex1,Pause,Ex2,Upd)
  // 9 SelIR 10..15 IR column (Cap,Sh,Ex1,Pause,Ex2,Upd)
  logic [3:0] code_t [16] = '{4'hF, 4'hC, 4'h7, 4'h6, 4'h2, 4'h1, 4'h3, 4'h0,
                              4'h5, 4'h4, 4'hE, 4'hA, 4'h9, 4'hB, 4'h8, 4'hD};
  int   ms;
  logic tdo_m, oe_m;
  int   last_cir, last_cdr, last_uir, last_udr;
  int   acc_cir, acc_cdr, acc_uir, acc_udr;

  always #5 ICLK = ~ICLK;

  jtag_tap_fsm #(.SYNC_STAGES(2)) dut (
    .ICLK(ICLK), .reset(reset), .tck(tck), .tms(tms), .tdi(tdi),
    .ir_s_out(ir_s_out), .dr_s_out(dr_s_out), .tdo(tdo), .tdo_oe(tdo_oe),
    .shift_ir(shift_ir), .clk_ir(clk_ir), .update_ir(update_ir),
    .shift_dr(shift_dr), .clk_dr(clk_dr), .update_dr(update_dr),
    .test_logic_reset(test_logic_reset), .tap_state(tap_state)
  );

  function automatic int model_next(int s, bit m);
    int base, k;
    case (s)
      0: return m ? 0 : 1;
      1: return m ? 2 : 1;
      2: return m ? 9 : 3;
      9: return m ? 0 : 10;
      default: begin
        base = (s >= 10) ? 10 : 3;
        k    = s - base;
        case (k)
          0, 1: k = m ? 2 : 1;
          2:    k = m ? 5 : 3;
          3:    k = m ? 4 : 3;
          4:    k = m ? 5 : 1;
          default: return m ? 2 : 1;  // Update exits the column
        endcase
        return base + k;
      end
    endcase
  endfunction

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    tests++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One full TCK period (high then low) with the given tms and serial-out values
  task automatic tck_cycle(input bit m, input bit ir_v, input bit dr_v);
    int   pre, nx;
    logic sir_at, sdr_at;
    pre = ms;
    nx  = model_next(ms, m);
    last_cir = 0; last_cdr = 0; last_uir = 0; last_udr = 0;
    sir_at = 1'b0; sdr_at = 1'b0;
    tms = m; ir_s_out = ir_v; dr_s_out = dr_v; tdi = 1'($urandom);
    tck = 1'b1;
    for (int i = 0; i < 2 * PH; i++) begin
      @(negedge ICLK);
      if (clk_ir)    begin last_cir++; sir_at = shift_ir; end
      if (clk_dr)    begin last_cdr++; sdr_at = shift_dr; end
      if (update_ir) last_uir++;
      if (update_dr) last_udr++;
      if (i == PH - 1) tck = 1'b0;
    end
    ms = nx;
    if (nx == 11) begin tdo_m = ir_v; oe_m = 1'b1; end
    else if (nx == 4) begin tdo_m = dr_v; oe_m = 1'b1; end
    else oe_m = 1'b0;
    chk("clk_ir_n", 4'(last_cir), {3'b0, pre == 10 || pre == 11});
    chk("clk_dr_n", 4'(last_cdr), {3'b0, pre == 3 || pre == 4});
    if (last_cir == 1) chk("shift_ir@clk_ir", {3'b0, sir_at}, {3'b0, pre == 11});
    if (last_cdr == 1) chk("shift_dr@clk_dr", {3'b0, sdr_at}, {3'b0, pre == 4});
    chk("update_ir_n", 4'(last_uir), {3'b0, nx == 15});
    chk("update_dr_n", 4'(last_udr), {3'b0, nx == 8});
    chk("tap_state", tap_state, code_t[nx]);
    chk("shift_ir", {3'b0, shift_ir}, {3'b0, nx == 11});
    chk("shift_dr", {3'b0, shift_dr}, {3'b0, nx == 4});
    chk("tlr", {3'b0, test_logic_reset}, {3'b0, nx == 0});
    chk("tdo_oe", {3'b0, tdo_oe}, {3'b0, oe_m});
    chk("tdo", {3'b0, tdo}, {3'b0, tdo_m});
    acc_cir += last_cir; acc_cdr += last_cdr;
    acc_uir += last_uir; acc_udr += last_udr;
  endtask

  // Asynchronous reset pulse placed between ICLK edges, with immediate checks
  task automatic pulse_reset();
    #2 reset = 1'b1;
    #1;
    chk("rst_state", tap_state, 4'hF);
    chk("rst_oe", {3'b0, tdo_oe}, 4'h0);
    chk("rst_shift_ir", {3'b0, shift_ir}, 4'h0);
    chk("rst_strobes", {clk_ir, update_ir, clk_dr, update_dr}, 4'h0);
    repeat (3) @(negedge ICLK);
    reset = 1'b0;
    ms = 0; tdo_m = 1'b0; oe_m = 1'b0;
    chk("rst_tdo", {3'b0, tdo}, 4'h0);
    chk("rst_tlr", {3'b0, test_logic_reset}, 4'h1);
  endtask

  initial begin
    logic [3:0] exp_seq [5];
    bit         m_seq   [7];
    reset = 1'b1; tck = 1'b0; tms = 1'b0; tdi = 1'b0; ir_s_out = 1'b0; dr_s_out = 1'b0;
    ms = 0; tdo_m = 1'b0; oe_m = 1'b0;
    acc_cir = 0; acc_cdr = 0; acc_uir = 0; acc_udr = 0;
    repeat (3) @(negedge ICLK);
    chk("init_state", tap_state, 4'hF);
    chk("init_tdo", {2'b0, tdo, tdo_oe}, 4'h0);
    chk("init_tlr", {3'b0, test_logic_reset}, 4'h1);
    reset = 1'b0;

    // Walk to Shift-IR, shift once, then reset mid-shift
    tck_cycle(1'b0, 1'b0, 1'b0);
    tck_cycle(1'b1, 1'b0, 1'b0);
    tck_cycle(1'b1, 1'b0, 1'b0);
    tck_cycle(1'b0, 1'b0, 1'b0);
    tck_cycle(1'b0, 1'b1, 1'b0);
    tck_cycle(1'b0, 1'b1, 1'b0);
    chk("pre_rst_shir", tap_state, 4'hA);
    pulse_reset();
    for (int i = 0; i < 5; i++) tck_cycle(1'b1, 1'b0, 1'b0);
    chk("tlr_hold_state", tap_state, 4'hF);
    chk("tlr_hold_level", {3'b0, test_logic_reset}, 4'h1);

    // TLR -> RTI -> SelDR -> SelIR -> CapIR -> ShIR
    exp_seq = '{4'hC, 4'h7, 4'h4, 4'hE, 4'hA};
    m_seq   = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    for (int i = 0; i < 4; i++) begin
      tck_cycle(m_seq[i], 1'b0, 1'b0);
      chk("ir_walk", tap_state, exp_seq[i]);
    end
    tck_cycle(1'b0, 1'b0, 1'b0);
    chk("capir_pulse", 4'(last_cir), 4'h1);
    chk("enter_shir", tap_state, 4'hA);

    // Shift four IR bits, last with tms=1
    acc_cir = 0;
    tck_cycle(1'b0, 1'b1, 1'b0);
    chk("shir_tdo0", {2'b0, tdo_oe, tdo}, 4'h3);
    tck_cycle(1'b0, 1'b0, 1'b0);
    chk("shir_tdo1", {2'b0, tdo_oe, tdo}, 4'h2);
    tck_cycle(1'b0, 1'b1, 1'b0);
    chk("shir_tdo2", {2'b0, tdo_oe, tdo}, 4'h3);
    tck_cycle(1'b1, 1'b1, 1'b0);
    chk("ex1ir_oe", {2'b0, tdo_oe, tdo}, 4'h1);
    chk("ex1ir_state", tap_state, 4'h9);
    chk("shir_clk_ir_total", 4'(acc_cir), 4'h4);

    // Update-IR, then back to RTI
    tck_cycle(1'b1, 1'b0, 1'b0);
    chk("updir_state", tap_state, 4'hD);
    chk("updir_pulse", 4'(last_uir), 4'h1);
    tck_cycle(1'b0, 1'b0, 1'b0);
    chk("updir_exit", tap_state, 4'hC);
    chk("updir_no_repeat", 4'(last_uir), 4'h0);

    // DR scan path
    acc_cir = 0; acc_cdr = 0; acc_uir = 0; acc_udr = 0;
    m_seq = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    for (int i = 0; i < 7; i++) tck_cycle(m_seq[i], 1'($urandom), 1'($urandom));
    chk("dr_clk_dr_total", 4'(acc_cdr), 4'h3);
    chk("dr_update_total", 4'(acc_udr), 4'h1);
    chk("dr_no_ir", 4'(acc_cir + acc_uir), 4'h0);
    chk("dr_end_state", tap_state, 4'hC);

    // Pause loop within the DR column
    tck_cycle(1'b1, 1'b0, 1'b0);
    tck_cycle(1'b0, 1'b0, 1'b0);
    tck_cycle(1'b0, 1'b0, 1'b1);
    chk("pause_start", tap_state, 4'h2);
    acc_cdr = 0;
    exp_seq = '{4'h1, 4'h3, 4'h3, 4'h0, 4'h2};
    m_seq   = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    for (int i = 0; i < 5; i++) begin
      tck_cycle(m_seq[i], 1'b0, 1'($urandom));
      chk("pause_walk", tap_state, exp_seq[i]);
    end
    chk("pause_clk_dr_total", 4'(acc_cdr), 4'h1);

    // Randomized traffic with occasional resets
    for (int n = 0; n < 300; n++) begin
      if ($urandom_range(0, 49) == 0) pulse_reset();
      else tck_cycle(1'($urandom_range(0, 9) < 4), 1'($urandom), 1'($urandom));
    end

    $display("[TB] %0d tests run, %0d failed", tests, errs);
    $finish;
  end

  // Global time limit so the run cannot hang
  initial begin
    #2000000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/jtag_tap_fsm.md
Name: jtag_tap_fsm

Overview:
IEEE 1149.1 TAP controller that runs entirely on the system clock ICLK. It oversamples the external TCK/TMS/TDI pins and steps the 16-state TAP machine once per detected TCK rising edge. It generates the single-ICLK-cycle strobes that drive the per-bit instruction-register cells and data-register cells (shift_ir/clk_ir/update_ir and the DR equivalents). It also drives TDO from the selected serial chain on TCK falling edges.

Parameters:
SYNC_STAGES, 2, number of flops in each pin synchroniser (tck, tms, tdi); minimum 2.

Ports:
ICLK  input  1  system clock; all state changes on its rising edge
reset  input  1  asynchronous, active-high reset
tck  input  1  raw JTAG clock pin, asynchronous to ICLK
tms  input  1  raw JTAG mode select pin
tdi  input  1  raw JTAG data in pin
ir_s_out  input  1  serial output of last IR cell
dr_s_out  input  1  serial output of selected DR chain
tdo  output  1  JTAG data out, registered
tdo_oe  output  1  tdo output enable
shift_ir  output  1  level: state == Shift-IR
clk_ir  output  1  IR capture/shift enable strobe, 1 ICLK cycle
update_ir  output  1  IR update strobe, 1 ICLK cycle
shift_dr  output  1  level: state == Shift-DR
clk_dr  output  1  DR capture/shift enable strobe
update_dr  output  1  DR update strobe
test_logic_reset  output  1  level: state == Test-Logic-Reset
tap_state  output  4  current state encoding

Behaviour:
- Synchronisers: tck, tms and tdi each pass through SYNC_STAGES flops. tms and tdi share tck's delay, so they stay aligned with it.
- Edge detection: one extra flop holds the previous synchronised tck.
  - tck_rise = sync & ~prev; tck_fall = ~sync & prev.
  - Both are one ICLK cycle wide and can never be high in the same cycle.
- State encoding (tap_state, hex): TLR F, RTI C, SelDR 7, CapDR 6, ShDR 2, Ex1DR 1, PauseDR 3, Ex2DR 0, UpdDR 5, SelIR 4, CapIR E, ShIR A, Ex1IR 9, PauseIR B, Ex2IR 8, UpdIR D.
- Transitions: standard 1149.1, evaluated on the ICLK edge where tck_rise=1, using synchronised tms. State holds in all other cycles.
  - TLR: tms 0 -> RTI, 1 -> stay.
  - RTI: 1 -> SelDR.
  - SelDR: 0 -> CapDR, 1 -> SelIR.
  - SelIR: 0 -> CapIR, 1 -> TLR.
  - Cap: 0 -> Sh, 1 -> Ex1.
  - Sh: 1 -> Ex1.
  - Ex1: 0 -> Pause, 1 -> Upd.
  - Pause: 1 -> Ex2.
  - Ex2: 0 -> Sh, 1 -> Upd.
  - Upd: 0 -> RTI, 1 -> SelDR.
  - Any state not listed for a tms value stays put.
- Five consecutive tms=1 TCK rises reach TLR from any state.
- Strobes are combinational from the registered state and the registered edge strobes, so a cell clocked on the same ICLK edge sees the pre-transition state:
  - clk_ir = tck_rise & (state==CapIR | state==ShIR). In CapIR, shift_ir=0, so cells load parallel data; in ShIR, shift_ir=1, so cells shift.
  - update_ir = tck_fall & state==UpdIR, giving exactly one pulse per UpdIR visit.
  - clk_dr, update_dr and shift_dr follow the same rules for the DR states.
- TDO, updated on tck_fall:
  - state ShIR: tdo <= ir_s_out, tdo_oe <= 1.
  - state ShDR: tdo <= dr_s_out, tdo_oe <= 1.
  - otherwise: tdo_oe <= 0 and tdo holds.
- Reset (async assert, applied immediately, including mid-shift):
  - state = TLR; sync and edge flops = 0.
  - tdo = 0, tdo_oe = 0; all strobes = 0.
  - test_logic_reset = 1.
- Timing constraint: TCK high and low phases must each be ≥ SYNC_STAGES+2 ICLK periods. Shorter phases may drop edges; no detection of this is required.

Test Plan:
- Assert reset during ShIR -> tap_state=F, tdo_oe=0, shift_ir=0 within the same cycle. Release reset, 5 TCK with tms=1 -> tap_state remains F, test_logic_reset=1.
- From TLR, tms 0,1,1,0 -> tap_state C,7,4,E. Next TCK with tms=0 -> exactly one clk_ir pulse with shift_ir=0, then tap_state=A.
- In ShIR, 4 TCK with tms 0,0,0,1, ir_s_out=1,0,1,1 -> 4 clk_ir pulses all with shift_ir=1. tdo samples 1,0,1 then tdo_oe drops on the fall after entering Ex1IR (tap_state=9).
- From Ex1IR, tms=1 -> tap_state=D, exactly one update_ir pulse on the following tck_fall. Then tms=0 -> tap_state=C, with no further update_ir pulses.
- DR path: from RTI, tms 1,0,0,0,1,1,0 -> clk_dr 3 pulses (1 capture, 2 shift) and one update_dr pulse; ends at tap_state=C. No IR strobes fire at any point.
- Pause loop: in ShDR, tms 1,0,0,1,0 -> tap_state 1,3,3,0,2. clk_dr fires only on rises taken from ShDR.
